// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI readout arbiter: FSM encoding,
// requester identity, the default idle word and counter widths.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOST = 2'd1,
      ST_AUTO = 2'd2
   } arb_state_e;

   typedef enum logic {
      GRANT_HOST = 1'b0,
      GRANT_AUTO = 1'b1
   } grant_e;

   localparam logic [31:0] IDLE_WORD_DEFAULT = 32'h3D3D3D3D;

   localparam int WORD_CNT_W  = 8;
   localparam int STALL_CNT_W = 12;
   localparam int BURST_CNT_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous levels into the
// clock domain; output follows the input two clock edges later.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // NOTE: no reset here on purpose; the chain flushes itself within two
   // cycles, and leaving it live keeps a held level visible right after reset.
   always_ff @(posedge clock) begin
      meta_q <= d;
      sync_q <= meta_q;
   end

   assign q = sync_q;

endmodule

// File: rtl/spi_readout_arbiter.sv
// Shares the spi_readout command stream between host configuration words and
// interrupt-driven bursts of idle words, presented as an FWFT FIFO.
module spi_readout_arbiter
   import spi_arb_pkg::*;
#(
   parameter logic [31:0] IDLE_WORD  = IDLE_WORD_DEFAULT,
   parameter int          AUTO_WORDS = 8,
   parameter int          HOST_BURST = 16,
   parameter int          TIMEOUT    = 4095
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        interrupt,
   input  logic [31:0] host_fifo_dout,
   input  logic        host_fifo_empty,
   output logic        host_fifo_rd_en,
   output logic [31:0] spi_fifo_dout,
   output logic        spi_fifo_empty,
   input  logic        spi_fifo_rd_en,
   output logic        grant_host,
   output logic        grant_auto,
   output logic [15:0] burst_count,
   output logic        timeout_err
);

   localparam logic [WORD_CNT_W-1:0]  AUTO_LAST  = WORD_CNT_W'(AUTO_WORDS - 1);
   localparam logic [WORD_CNT_W-1:0]  HOST_LAST  = WORD_CNT_W'(HOST_BURST - 1);
   localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(TIMEOUT - 1);

   arb_state_e             state_q, state_d;
   grant_e                 last_grant_q, last_grant_d;
   logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic                   timeout_err_q, timeout_err_d;
   logic                   grant_host_q, grant_host_d;
   logic                   grant_auto_q, grant_auto_d;

   logic irq_n_s;
   logic auto_req;
   logic host_pending;

   sync_2ff #(.WIDTH(1)) u_irq_sync (
      .clock (clock),
      .d     (interrupt),
      .q     (irq_n_s)
   );

   assign auto_req     = enable & ~irq_n_s;
   assign host_pending = ~host_fifo_empty;

   // NOTE: every always_comb output gets a default first so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      word_cnt_d      = word_cnt_q;
      stall_cnt_d     = stall_cnt_q;
      burst_cnt_d     = burst_cnt_q;
      timeout_err_d   = timeout_err_q;
      host_fifo_rd_en = 1'b0;
      spi_fifo_dout   = '0;
      spi_fifo_empty  = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            word_cnt_d  = '0;
            stall_cnt_d = '0;
            if (auto_req && host_pending) begin
               state_d = (last_grant_q == GRANT_HOST) ? ST_AUTO : ST_HOST;
            end else if (auto_req) begin
               state_d = ST_AUTO;
            end else if (host_pending) begin
               state_d = ST_HOST;
            end
         end

         ST_HOST: begin
            spi_fifo_dout   = host_fifo_dout;
            spi_fifo_empty  = host_fifo_empty;
            // Pop is withheld during reset so an aborted grant never eats a word.
            host_fifo_rd_en = spi_fifo_rd_en & host_pending & ~reset;
            if (!host_pending) begin
               state_d      = ST_IDLE;
               last_grant_d = GRANT_HOST;
            end else if (spi_fifo_rd_en) begin
               word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
               if (word_cnt_q == HOST_LAST) begin
                  state_d      = ST_IDLE;
                  last_grant_d = GRANT_HOST;
               end
            end
         end

         ST_AUTO: begin
            spi_fifo_dout  = IDLE_WORD;
            spi_fifo_empty = 1'b0;
            if (spi_fifo_rd_en) begin
               word_cnt_d  = word_cnt_q + WORD_CNT_W'(1);
               stall_cnt_d = '0;
               if (word_cnt_q == AUTO_LAST) begin
                  burst_cnt_d  = burst_cnt_q + BURST_CNT_W'(1);
                  last_grant_d = GRANT_AUTO;
                  state_d      = ST_IDLE;
               end
            end else if (stall_cnt_q == STALL_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase

      grant_host_d = (state_d == ST_HOST);
      grant_auto_d = (state_d == ST_AUTO);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= GRANT_HOST;
         word_cnt_q    <= '0;
         stall_cnt_q   <= '0;
         burst_cnt_q   <= '0;
         timeout_err_q <= 1'b0;
         grant_host_q  <= 1'b0;
         grant_auto_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         word_cnt_q    <= word_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         burst_cnt_q   <= burst_cnt_d;
         timeout_err_q <= timeout_err_d;
         grant_host_q  <= grant_host_d;
         grant_auto_q  <= grant_auto_d;
      end
   end

   assign grant_host  = grant_host_q;
   assign grant_auto  = grant_auto_q;
   assign burst_count = burst_cnt_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spi_readout_arbiter.sv
// Self-checking bench: a transaction-level model of who owns the stream and
// how many words each owner has served, compared every cycle, plus directed checks.
module tb_spi_readout_arbiter;

   localparam logic [31:0] IDLE_W = 32'h3D3D3D3D;
   localparam int AUTO_N = 8;
   localparam int HOST_N = 16;
   localparam int TMO    = 4095;

   localparam int OWN_NONE = 0;
   localparam int OWN_HOST = 1;
   localparam int OWN_AUTO = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        interrupt = 1'b1;
   logic [31:0] host_fifo_dout;
   logic        host_fifo_empty;
   logic        host_fifo_rd_en;
   logic [31:0] spi_fifo_dout;
   logic        spi_fifo_empty;
   logic        spi_fifo_rd_en = 1'b0;
   logic        grant_host;
   logic        grant_auto;
   logic [15:0] burst_count;
   logic        timeout_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   spi_readout_arbiter #(
      .IDLE_WORD  (IDLE_W),
      .AUTO_WORDS (AUTO_N),
      .HOST_BURST (HOST_N),
      .TIMEOUT    (TMO)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .interrupt       (interrupt),
      .host_fifo_dout  (host_fifo_dout),
      .host_fifo_empty (host_fifo_empty),
      .host_fifo_rd_en (host_fifo_rd_en),
      .spi_fifo_dout   (spi_fifo_dout),
      .spi_fifo_empty  (spi_fifo_empty),
      .spi_fifo_rd_en  (spi_fifo_rd_en),
      .grant_host      (grant_host),
      .grant_auto      (grant_auto),
      .burst_count     (burst_count),
      .timeout_err     (timeout_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Host FIFO environment: FWFT queue, popped at the clock edge.
   logic [31:0] host_q[$];
   bit          pending_pop = 1'b0;

   task automatic refresh_host();
      host_fifo_empty = (host_q.size() == 0);
      host_fifo_dout  = (host_q.size() == 0) ? 32'h0 : host_q[0];
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (pending_pop && host_q.size() > 0) void'(host_q.pop_front());
      refresh_host();
   endtask

   // Behavioural model: current owner, words served this grant, idle cycles.
   int  m_owner     = OWN_NONE;
   int  m_served    = 0;
   int  m_stall     = 0;
   bit  m_auto_last = 1'b0;
   int  m_bursts    = 0;
   bit  m_terr      = 1'b0;
   bit  m_int_hist[2] = '{1'b1, 1'b1};
   bit  started     = 1'b0;

   logic [31:0] seen_words[$];
   int          host_pops  = 0;
   int          idle_words = 0;
   int          grant_log[$];
   int          prev_obs   = OWN_NONE;

   task automatic clear_logs();
      seen_words.delete();
      grant_log.delete();
      host_pops  = 0;
      idle_words = 0;
      prev_obs   = OWN_NONE;
   endtask

   always @(negedge clock) begin : compare_proc
      logic [31:0] e_dout;
      logic        e_empty, e_rd;
      bit          areq, hpend;
      areq  = enable && !m_int_hist[1];
      hpend = !host_fifo_empty;
      if (started) begin
         e_dout = 32'h0; e_empty = 1'b1; e_rd = 1'b0;
         if (m_owner == OWN_HOST) begin
            e_dout  = host_fifo_dout;
            e_empty = host_fifo_empty;
            e_rd    = spi_fifo_rd_en && hpend && !reset;
         end else if (m_owner == OWN_AUTO) begin
            e_dout  = IDLE_W;
            e_empty = 1'b0;
         end
         check("grant_host", grant_host, m_owner == OWN_HOST);
         check("grant_auto", grant_auto, m_owner == OWN_AUTO);
         check("spi_fifo_empty", spi_fifo_empty, e_empty);
         check("spi_fifo_dout", spi_fifo_dout, e_dout);
         check("host_fifo_rd_en", host_fifo_rd_en, e_rd);
         check("burst_count", burst_count, 32'(m_bursts[15:0]));
         check("timeout_err", timeout_err, m_terr);
         if (spi_fifo_rd_en && !spi_fifo_empty && !reset) begin
            seen_words.push_back(spi_fifo_dout);
            if (grant_auto) idle_words++;
         end
         if (host_fifo_rd_en) host_pops++;
         if (grant_host && prev_obs != OWN_HOST) grant_log.push_back(OWN_HOST);
         if (grant_auto && prev_obs != OWN_AUTO) grant_log.push_back(OWN_AUTO);
         prev_obs = grant_host ? OWN_HOST : (grant_auto ? OWN_AUTO : OWN_NONE);
      end
      pending_pop = host_fifo_rd_en;

      // Advance the model across the coming edge.
      if (reset) begin
         m_owner = OWN_NONE; m_served = 0; m_stall = 0;
         m_auto_last = 1'b0; m_bursts = 0; m_terr = 1'b0;
      end else if (m_owner == OWN_NONE) begin
         m_served = 0; m_stall = 0;
         if (areq && hpend) m_owner = m_auto_last ? OWN_HOST : OWN_AUTO;
         else if (areq)     m_owner = OWN_AUTO;
         else if (hpend)    m_owner = OWN_HOST;
      end else if (m_owner == OWN_HOST) begin
         if (!hpend) begin
            m_owner = OWN_NONE; m_auto_last = 1'b0;
         end else if (spi_fifo_rd_en) begin
            m_served++;
            if (m_served == HOST_N) begin m_owner = OWN_NONE; m_auto_last = 1'b0; end
         end
      end else begin
         if (spi_fifo_rd_en) begin
            m_served++; m_stall = 0;
            if (m_served == AUTO_N) begin
               m_bursts = (m_bursts + 1) % 65536; m_auto_last = 1'b1; m_owner = OWN_NONE;
            end
         end else begin
            m_stall++;
            if (m_stall == TMO) begin m_terr = 1'b1; m_owner = OWN_NONE; end
         end
      end
      m_int_hist[1] = m_int_hist[0];
      m_int_hist[0] = interrupt;
      if (reset) started = 1'b1;
   end

   initial begin : stimulus
      int n;
      int cnt;
      int exp_log[6] = '{OWN_AUTO, OWN_HOST, OWN_AUTO, OWN_HOST, OWN_AUTO, OWN_HOST};
      refresh_host();
      repeat (3) tick();

      // Reset state
      check("rst_spi_empty", spi_fifo_empty, 1);
      check("rst_spi_dout", spi_fifo_dout, 0);
      check("rst_grant_host", grant_host, 0);
      check("rst_grant_auto", grant_auto, 0);
      check("rst_burst_count", burst_count, 0);
      check("rst_timeout_err", timeout_err, 0);

      // Host only: three words, consumer pops every cycle
      for (int i = 1; i <= 3; i++) host_q.push_back(32'hA000_0000 + 32'(i));
      refresh_host();
      clear_logs();
      spi_fifo_rd_en = 1'b1;
      reset = 1'b0;
      check("host_grant_during_idle", grant_host, 0);
      tick();
      check("host_grant_after_idle", grant_host, 1);
      repeat (6) tick();
      check("host_pops", host_pops, 3);
      check("host_seen_cnt", seen_words.size(), 3);
      for (int i = 0; i < 3 && i < seen_words.size(); i++)
         check("host_word", seen_words[i], 32'hA000_0000 + 32'(i + 1));
      check("host_back_idle", grant_host, 0);

      // Interrupt only: 2 sync cycles + 1 IDLE, then 8 idle words
      clear_logs();
      enable = 1'b1;
      interrupt = 1'b0;
      tick(); tick();
      check("auto_not_yet", grant_auto, 0);
      tick();
      check("auto_grant_latency", grant_auto, 1);
      n = 0;
      while (burst_count != 16'd1 && n < 40) begin tick(); n++; end
      check("auto_burst1", burst_count, 1);
      check("auto_idle_words", idle_words, 8);
      check("auto_gap_idle", grant_auto, 0);
      tick();
      check("auto_restart", grant_auto, 1);
      interrupt = 1'b1;
      n = 0;
      while (burst_count != 16'd2 && n < 40) begin tick(); n++; end
      check("auto_burst2_full", burst_count, 2);
      check("auto_idle_words2", idle_words, 16);
      repeat (4) tick();
      check("auto_stops", grant_auto, 0);

      // Tie from reset with 40 host words: AUTO first, then HOST 16 at a time
      reset = 1'b1;
      interrupt = 1'b0;
      for (int i = 0; i < 40; i++) host_q.push_back(32'hB000_0000 + 32'(i));
      refresh_host();
      repeat (3) tick();
      clear_logs();
      reset = 1'b0;
      n = 0;
      while (host_pops < 40 && n < 400) begin tick(); n++; end
      check("tie_host_pops", host_pops, 40);
      check("tie_log_len", grant_log.size() >= 6, 1);
      for (int i = 0; i < 6; i++)
         check("tie_grant_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_log[i]);
      check("tie_first_word", seen_words.size() > 8 ? seen_words[0] : 32'h0, IDLE_W);
      check("tie_first_host", seen_words.size() > 8 ? seen_words[8] : 32'h0, 32'hB000_0000);
      interrupt = 1'b1;

      // Randomized traffic against the model
      for (int i = 0; i < 2500; i++) begin
         spi_fifo_rd_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0 && host_q.size() < 24) host_q.push_back($urandom);
         if ($urandom_range(0, 39) == 0) interrupt = ~interrupt;
         if ($urandom_range(0, 99) == 0) enable = ~enable;
         reset = ($urandom_range(0, 249) == 0);
         refresh_host();
         tick();
      end

      // Stall: AUTO with no pops times out after TMO cycles
      reset = 1'b1;
      enable = 1'b1;
      interrupt = 1'b0;
      spi_fifo_rd_en = 1'b0;
      host_q.delete();
      refresh_host();
      repeat (3) tick();
      reset = 1'b0;
      n = 0;
      while (!grant_auto && n < 10) begin tick(); n++; end
      check("stall_auto_start", grant_auto, 1);
      n = 0;
      while (grant_auto && n < 5000) begin tick(); n++; end
      check("stall_cycles", n, TMO);
      check("stall_timeout_err", timeout_err, 1);
      check("stall_burst_unchanged", burst_count, 0);

      // Reset after 3 AUTO pops of the restarted burst
      tick();
      check("rst_mid_auto_start", grant_auto, 1);
      spi_fifo_rd_en = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      spi_fifo_rd_en = 1'b0;
      tick();
      check("rst_mid_spi_empty", spi_fifo_empty, 1);
      check("rst_mid_grant_auto", grant_auto, 0);
      check("rst_mid_burst", burst_count, 0);
      check("rst_mid_timeout_err", timeout_err, 0);

      // Gating: enable low keeps readout silent
      enable = 1'b0;
      tick();
      reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!spi_fifo_empty) cnt++;
      end
      check("gate_never_nonempty", cnt, 0);
      check("gate_no_grant", grant_auto, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
